// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, FSM encoding and address helper for the line read controller
package mem_pkg;

  localparam int ADDR_W          = 13;
  localparam int DATA_W          = 32;
  localparam int BYTE_W          = 8;
  localparam int DEFAULT_LATENCY = 4;

  // Gray-style sequence: every legal transition changes exactly one bit.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    READ = 2'b11,
    DONE = 2'b10
  } state_t;

  // Word-aligned base of the line holding byte address a.
  function automatic logic [ADDR_W-1:0] word_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_byte_rom.sv
// rtl/mem_byte_rom.sv - 8192x8 synchronous-read byte ROM
//
// Ports:
//   clk   in   system clock; dout updates on posedge
//   addr  in   [12:0] byte address
//   dout  out  [7:0] byte at addr, one cycle after addr is presented
//
// Contents: each location holds the low byte of its own address, so
// byte[a] = a[7:0].
module mem_byte_rom
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [BYTE_W-1:0] dout
);

  // Only the low byte of the address selects the stored pattern.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[ADDR_W-1:BYTE_W];

  always_ff @(posedge clk) begin
    dout <= addr[BYTE_W-1:0];
  end

endmodule

// File: rtl/mem_read_ctrl.sv
// rtl/mem_read_ctrl.sv - reads a 4-byte line from the byte ROM after a fixed access wait
//
// Ports:
//   clk     in   system clock, all logic on posedge
//   reset   in   synchronous, active-high
//   rreq    in   line read request; sampled only in IDLE
//   raddr   in   [12:0] byte address, bits [1:0] ignored
//   rdata   out  [31:0] assembled line, byte base+n in bits [8n+7:8n]
//   rvalid  out  one-cycle pulse marking rdata valid
//   busy    out  high in every state except IDLE
//
// LATENCY (1..15) is the number of WAIT cycles before the first ROM access.
module mem_read_ctrl
  import mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rreq,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);
  localparam logic [2:0] LAST_BEAT = 3'd4;

  state_t            state, next_state;
  logic [ADDR_W-1:0] base;
  logic [3:0]        wait_cnt;
  logic [2:0]        beat;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] rom_addr;
  logic [BYTE_W-1:0] rom_dout;

  // Beat 4 wraps rom_addr back to base; that read is never captured.
  assign rom_addr = base + ADDR_W'(beat[1:0]);

  // The ROM answers one beat late, so beat n carries the byte for lane n-1.
  assign lane = 2'(beat - 3'd1);

  mem_byte_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .dout (rom_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    rvalid     = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (rreq) next_state = WAIT;
      end
      WAIT: begin
        if (wait_cnt == 4'd0) next_state = READ;
      end
      READ: begin
        if (beat == LAST_BEAT) next_state = DONE;
      end
      DONE: begin
        rvalid     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base     <= '0;
      wait_cnt <= '0;
      beat     <= '0;
      rdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rreq) begin
            base     <= word_base(raddr);
            wait_cnt <= WAIT_LOAD;
            beat     <= '0;
          end
        end
        WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            beat <= '0;
          end
        end
        READ: begin
          beat <= beat + 3'd1;
          if (beat != 3'd0) begin
            rdata[lane*BYTE_W +: BYTE_W] <= rom_dout;
          end
        end
        default: begin
          // DONE: rdata holds until the next line's first capture.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_ctrl.sv
// tb/tb_mem_read_ctrl.sv - randomized self-checking bench for mem_read_ctrl
module tb_mem_read_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rreq4, rreq1;
  logic [12:0] raddr4, raddr1;
  logic [31:0] rdata4, rdata1;
  logic        rvalid4, rvalid1;
  logic        busy4, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_read_ctrl #(.LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .rreq(rreq4), .raddr(raddr4),
    .rdata(rdata4), .rvalid(rvalid4), .busy(busy4)
  );

  mem_read_ctrl #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .rreq(rreq1), .raddr(raddr1),
    .rdata(rdata1), .rvalid(rvalid1), .busy(busy1)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the line is the four bytes starting at the address rounded
  // down to a multiple of 4; ROM byte value is the address modulo 256.
  function automatic logic [31:0] model_line(input int a);
    logic [31:0] line = 32'h0;
    int b = (a / 4) * 4;
    for (int n = 0; n < 4; n++) line |= 32'((b + n) % 256) << (8 * n);
    return line;
  endfunction

  function automatic logic get_rv(input bit sel);
    return sel ? rvalid1 : rvalid4;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy1 : busy4;
  endfunction

  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? rdata1 : rdata4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request pulse on an idle DUT; sel=1 picks the LATENCY=1 instance.
  task automatic txn(input bit sel, input logic [12:0] a);
    int lat = sel ? 1 : 4;
    int k = 0;
    int busy_n = 0;
    bit got = 0;
    if (sel) begin rreq1 = 1'b1; raddr1 = a; end
    else begin rreq4 = 1'b1; raddr4 = a; end
    tick();
    if (sel) begin rreq1 = 1'b0; raddr1 = 13'($urandom); end
    else begin rreq4 = 1'b0; raddr4 = 13'($urandom); end
    if (get_busy(sel)) busy_n++;
    while (!got && k < 40) begin
      tick();
      k++;
      if (get_rv(sel)) got = 1;
      else if (get_busy(sel)) busy_n++;
    end
    expect_eq($sformatf("latency[%h]", a), k, lat + 5);
    expect_eq($sformatf("busy_cycles[%h]", a), busy_n, lat + 5);
    expect_eq($sformatf("rdata[%h]", a), get_rdata(sel), model_line(int'(a)));
    expect_eq($sformatf("busy_done[%h]", a), get_busy(sel), 1);
    tick();
    expect_eq($sformatf("rvalid_after[%h]", a), get_rv(sel), 0);
    expect_eq($sformatf("busy_after[%h]", a), get_busy(sel), 0);
  endtask

  initial begin
    int pulses[$];
    int stray;
    int guard;

    reset = 1'b1;
    rreq4 = 1'b1; raddr4 = 13'h0104;
    rreq1 = 1'b0; raddr1 = 13'h0;
    repeat (3) tick();
    expect_eq("reset_rdata", rdata4, 32'h0);
    expect_eq("reset_rvalid", rvalid4, 0);
    expect_eq("reset_busy", busy4, 0);
    expect_eq("reset_busy_l1", busy1, 0);
    reset = 1'b0;

    txn(0, 13'h0104);
    txn(0, 13'h0107);
    txn(0, 13'h1FFC);
    txn(1, 13'h0040);

    // Request held high: back-to-back lines, raddr scrambled mid-line.
    rreq4 = 1'b1;
    raddr4 = 13'h0010;
    for (int t = 0; t < 34; t++) begin
      tick();
      if (rvalid4) begin
        pulses.push_back(t);
        expect_eq("cont_rdata", rdata4, 32'h13121110);
      end
      raddr4 = ((t % 11) >= 1 && (t % 11) <= 6) ? 13'($urandom) : 13'h0010;
    end
    rreq4 = 1'b0;
    expect_eq("cont_pulses", pulses.size(), 3);
    for (int i = 0; i < pulses.size(); i++) expect_eq("cont_time", pulses[i], 9 + 11 * i);
    guard = 0;
    while (busy4 && guard < 30) begin tick(); guard++; end
    expect_eq("cont_drain", busy4, 0);

    // Reset in READ beat 2 abandons the line.
    rreq4 = 1'b1; raddr4 = 13'h0030;
    tick();
    rreq4 = 1'b0;
    repeat (6) tick();
    expect_eq("pre_reset_busy", busy4, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_eq("midreset_rvalid", rvalid4, 0);
    expect_eq("midreset_rdata", rdata4, 32'h0);
    expect_eq("midreset_busy", busy4, 0);
    stray = 0;
    repeat (12) begin tick(); if (rvalid4) stray++; end
    expect_eq("midreset_no_rvalid", stray, 0);
    txn(0, 13'h0020);

    for (int i = 0; i < 24; i++) begin
      bit sel = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick();
      txn(sel, 13'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
